// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single-port data memory between the CPU MEM stage and the NoC
// network-interface port. The CPU has fixed priority. A starvation counter
// forces a NoC grant once the NoC has been refused NOC_MAX_WAIT times.
//
// Ports:
//   CLK, RESET            clock, asynchronous active-low reset
//   CPU_*                 MEM-stage load/store request; CPU_BUSYWAIT stalls the pipeline
//   NOC_*                 NI request; NOC_READDATA registered, NOC_ACK one-cycle pulse
//   MEM_*                 data memory strobes, address, data and busy handshake
//   DBG_STATE             current FSM state (0 idle, 1 cpu access, 2 noc access)
//   DBG_WAIT_CNT          current NoC starvation counter
//
// Handshake: a requester is pending while its READ or WRITE is high, and it
// holds address, data and type stable until told it is done. For the CPU,
// "done" is the cycle in which CPU_BUSYWAIT is low. For the NI, it is the
// NOC_ACK cycle. Memory side: a strobe stays high until a cycle with
// MEM_BUSYWAIT low, and that cycle completes the access.
module dmem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NOC_MAX_WAIT   = 8,
  parameter int WAIT_CNT_WIDTH = 4
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      CPU_READ,
  input  logic                      CPU_WRITE,
  input  logic [ADDR_WIDTH-1:0]     CPU_ADDR,
  input  logic [DATA_WIDTH-1:0]     CPU_WRITEDATA,
  output logic [DATA_WIDTH-1:0]     CPU_READDATA,
  output logic                      CPU_BUSYWAIT,
  input  logic                      NOC_READ,
  input  logic                      NOC_WRITE,
  input  logic [ADDR_WIDTH-1:0]     NOC_ADDR,
  input  logic [DATA_WIDTH-1:0]     NOC_WRITEDATA,
  output logic [DATA_WIDTH-1:0]     NOC_READDATA,
  output logic                      NOC_ACK,
  output logic                      MEM_READ,
  output logic                      MEM_WRITE,
  output logic [ADDR_WIDTH-1:0]     MEM_ADDR,
  output logic [DATA_WIDTH-1:0]     MEM_WRITEDATA,
  input  logic [DATA_WIDTH-1:0]     MEM_READDATA,
  input  logic                      MEM_BUSYWAIT,
  output logic [1:0]                DBG_STATE,
  output logic [WAIT_CNT_WIDTH-1:0] DBG_WAIT_CNT
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_ACC = 2'd1,
    NOC_ACC = 2'd2
  } state_t;

  localparam logic [WAIT_CNT_WIDTH-1:0] MAX_WAIT = WAIT_CNT_WIDTH'(NOC_MAX_WAIT);

  state_t                    state, next_state;
  logic [WAIT_CNT_WIDTH-1:0] wait_cnt;
  logic [ADDR_WIDTH-1:0]     lat_addr;
  logic [DATA_WIDTH-1:0]     lat_wdata;
  logic                      lat_wr;
  logic                      cpu_pend, noc_pend;
  logic                      grant_cpu, grant_noc;
  logic                      noc_done;

  assign cpu_pend  = CPU_READ | CPU_WRITE;
  assign noc_pend  = NOC_READ | NOC_WRITE;
  assign grant_cpu = (state == IDLE) && (next_state == CPU_ACC);
  assign grant_noc = (state == IDLE) && (next_state == NOC_ACC);
  assign noc_done  = (state == NOC_ACC) && !MEM_BUSYWAIT;

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic. Arbitration happens only in IDLE, so every access is
  // preceded by at least one strobe-low cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (noc_pend && (wait_cnt == MAX_WAIT)) next_state = NOC_ACC;
        else if (cpu_pend)                      next_state = CPU_ACC;
        else if (noc_pend)                      next_state = NOC_ACC;
        else                                    next_state = IDLE;
      end
      CPU_ACC, NOC_ACC: begin
        if (!MEM_BUSYWAIT) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Access latches. The memory side only ever sees these, so a requester that
  // changes or drops its inputs mid-access cannot disturb the access.
  // READ and WRITE both high counts as a write.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wr    <= 1'b0;
    end else if (grant_cpu) begin
      lat_addr  <= CPU_ADDR;
      lat_wdata <= CPU_WRITEDATA;
      lat_wr    <= CPU_WRITE;
    end else if (grant_noc) begin
      lat_addr  <= NOC_ADDR;
      lat_wdata <= NOC_WRITEDATA;
      lat_wr    <= NOC_WRITE;
    end
  end

  // Starvation counter: counts refused NoC cycles and saturates. The clear on
  // the grant edge takes precedence over the increment.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wait_cnt <= '0;
    end else if (grant_noc) begin
      wait_cnt <= '0;
    end else if (noc_pend && (state != NOC_ACC) && (wait_cnt != MAX_WAIT)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // NoC completion: capture read data (reads only) and pulse ACK next cycle.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      NOC_READDATA <= '0;
      NOC_ACK      <= 1'b0;
    end else begin
      NOC_ACK <= noc_done;
      if (noc_done && !lat_wr) NOC_READDATA <= MEM_READDATA;
    end
  end

  // Output logic
  always_comb begin
    MEM_READ     = 1'b0;
    MEM_WRITE    = 1'b0;
    CPU_BUSYWAIT = 1'b0;
    if ((state == CPU_ACC) || (state == NOC_ACC)) begin
      MEM_READ  = !lat_wr;
      MEM_WRITE = lat_wr;
    end
    CPU_BUSYWAIT = cpu_pend && !((state == CPU_ACC) && !MEM_BUSYWAIT);
  end

  assign MEM_ADDR      = lat_addr;
  assign MEM_WRITEDATA = lat_wdata;
  assign CPU_READDATA  = MEM_READDATA;
  assign DBG_STATE     = state;
  assign DBG_WAIT_CNT  = wait_cnt;

endmodule
